// File: rtl/frac_bin2bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : frac_bin2bcd_seq_pkg
// Purpose : Shared constants and FSM state encoding for the sequential
//           binary-to-BCD converter that sits behind the fraction-to-decimal
//           stage.
// Contents: W_DEF / ND_DEF / PW_DEF - default binary width, BCD digit count
//           and point-field width (shared with the fraction stage)
//           state_e                 - converter FSM states
// Revision: 1.0 - initial release
// ============================================================================
package frac_bin2bcd_seq_pkg;

    localparam int W_DEF  = 24;
    localparam int ND_DEF = 8;
    localparam int PW_DEF = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/frac_bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : frac_bin2bcd_seq_if
// Purpose : Upstream and downstream valid/ready handshake bundle of the
//           binary-to-BCD converter.
// Signals : in_valid/in_ready/bin_in/point_in   - request from fraction stage
//           out_valid/out_ready/bcd_out/point_out - result to display stage
//           busy                                - converter is shifting
// Modports: master - environment side (drives requests, accepts results)
//           slave  - converter side
// Revision: 1.0 - initial release
// ============================================================================
interface frac_bin2bcd_seq_if
    import frac_bin2bcd_seq_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int ND = ND_DEF,
    parameter int PW = PW_DEF
);

    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    bin_in;
    logic [PW-1:0]   point_in;
    logic            out_valid;
    logic            out_ready;
    logic [4*ND-1:0] bcd_out;
    logic [PW-1:0]   point_out;
    logic            busy;

    modport master (
        output in_valid, bin_in, point_in, out_ready,
        input  in_ready, out_valid, bcd_out, point_out, busy
    );

    modport slave (
        input  in_valid, bin_in, point_in, out_ready,
        output in_ready, out_valid, bcd_out, point_out, busy
    );

endinterface
`default_nettype wire

// File: rtl/frac_bin2bcd_seq_add3.sv
`default_nettype none
// ============================================================================
// Module  : frac_bin2bcd_seq_add3
// Purpose : Double-dabble digit correction: adds 3 to a BCD digit that is 5 or
//           more so the following left shift carries correctly into the next
//           decimal digit. Purely combinational.
// Ports   : digit_i [3:0] - BCD digit before correction
//           digit_o [3:0] - corrected digit (no carry out)
// Revision: 1.0 - initial release
// ============================================================================
module frac_bin2bcd_seq_add3 (
    input  wire logic [3:0] digit_i,
    output logic      [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule
`default_nettype wire

// File: rtl/frac_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : frac_bin2bcd_seq
// Purpose : Converts the W-bit binary decimal-fraction value to ND packed BCD
//           digits by shift-add-3 (double dabble), one bit per clock, and
//           forwards the leading-zero point count alongside the digits.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - handshake bundle (slave side):
//                   in_valid/in_ready/bin_in/point_in    request
//                   out_valid/out_ready/bcd_out/point_out result
//                   busy                                 high while shifting
// Timing  : result valid W clocks after the accept edge; one conversion per
//           W+2 clocks when the downstream is always ready.
// Revision: 1.0 - initial release
// ============================================================================
module frac_bin2bcd_seq
    import frac_bin2bcd_seq_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int ND = ND_DEF,
    parameter int PW = PW_DEF
) (
    input wire logic          clk,
    input wire logic          rst_n,
    frac_bin2bcd_seq_if.slave bus
);

    localparam int             CW       = $clog2(W);
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

    state_e            state_q, state_d;
    logic [W-1:0]      bin_q,   bin_d;
    logic [4*ND-1:0]   acc_q,   acc_d;
    logic [PW-1:0]     pnt_q,   pnt_d;
    logic [CW-1:0]     cnt_q,   cnt_d;
    logic [4*ND-1:0]   bcd_q,   bcd_d;
    logic [PW-1:0]     pout_q,  pout_d;
    logic              ov_q,    ov_d;

    // Accumulator after the per-digit +3 correction of this iteration.
    logic [4*ND-1:0]   adj_w;

    for (genvar gi = 0; gi < ND; gi++) begin : g_digit
        frac_bin2bcd_seq_add3 u_add3 (
            .digit_i (acc_q[4*gi +: 4]),
            .digit_o (adj_w[4*gi +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            pnt_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            pout_q  <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            pnt_q   <= pnt_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            pout_q  <= pout_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        pnt_d   = pnt_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        pout_d  = pout_q;
        ov_d    = ov_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    bin_d   = bus.bin_in;
                    acc_d   = '0;
                    pnt_d   = bus.point_in;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                // Corrected accumulator and binary register shift as one word.
                {acc_d, bin_d} = {adj_w[4*ND-2:0], bin_q, 1'b0};
                if (cnt_q == CNT_LAST) begin
                    // The last shift goes straight into the output register so
                    // the result appears on the same edge that enters DONE.
                    bcd_d   = {adj_w[4*ND-2:0], bin_q[W-1]};
                    pout_d  = pnt_q;
                    ov_d    = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    ov_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q == S_SHIFT);
    assign bus.out_valid = ov_q;
    assign bus.bcd_out   = bcd_q;
    assign bus.point_out = pout_q;

endmodule
`default_nettype wire

// File: tb/tb_frac_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_frac_bin2bcd_seq
// Purpose : Self-checking bench for frac_bin2bcd_seq. A driver pushes the
//           expected digits/point of every accepted request into a queue; a
//           monitor pops and compares on each output handshake and checks the
//           accept-to-valid latency.
// Revision: 1.0 - initial release
// ============================================================================
module tb_frac_bin2bcd_seq;
    import frac_bin2bcd_seq_pkg::*;

    localparam int W  = 24;
    localparam int ND = 8;
    localparam int PW = 5;

    typedef struct {
        logic [4*ND-1:0] bcd;
        logic [PW-1:0]   pt;
        int              acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    frac_bin2bcd_seq_if #(.W(W), .ND(ND), .PW(PW)) bus ();

    frac_bin2bcd_seq #(.W(W), .ND(ND), .PW(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sbq[$];
    exp_t mon_e;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [4*ND-1:0] to_bcd(input int unsigned v);
        logic [4*ND-1:0] r;
        int unsigned     x;
        r = '0;
        x = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Output monitor: latency on the first valid cycle, data on the handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                if (sbq.size() == 0) begin
                    check("unexp_ov", 64'(bus.out_valid), 64'd0);
                end else begin
                    if (!prev_ov) check("latency", 64'(cyc - sbq[0].acc), 64'd24);
                    if (bus.out_ready) begin
                        mon_e = sbq.pop_front();
                        check("bcd", 64'(bus.bcd_out), 64'(mon_e.bcd));
                        check("point", 64'(bus.point_out), 64'(mon_e.pt));
                    end
                end
            end
            prev_ov = bus.out_valid;
        end else begin
            prev_ov = 1'b0;
        end
    end

    // Driver tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [W-1:0] v, input logic [PW-1:0] p, output int acc);
        int n;
        bit ok;
        n  = 0;
        ok = 0;
        bus.bin_in   = v;
        bus.point_in = p;
        bus.in_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
            n++;
        end
        if (!ok) begin
            check("tmo_accept", 64'(bus.in_ready), 64'd1);
            acc = -1;
        end else begin
            acc = cyc + 1;
            sbq.push_back('{to_bcd(32'(v)), p, acc});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sbq.size() != 0) begin
            check("tmo_drain", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
    endtask

    logic [W-1:0]  vals[4] = '{24'hFFFFFF, 24'd1, 24'd12345, 24'd50000};
    logic [PW-1:0] pts[4]  = '{5'd1, 5'd3, 5'd0, 5'd31};

    initial begin
        int a, a1, a2, n;
        logic [4*ND-1:0] hold_bcd;

        bus.in_valid  = 1'b0;
        bus.bin_in    = '0;
        bus.point_in  = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_bcd", 64'(bus.bcd_out), 64'd0);
        check("rst_point", 64'(bus.point_out), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Zero input
        send(24'd0, 5'd0, a);
        wait_empty();

        // Largest 5-digit value, busy/in_ready while shifting
        send(24'd99999, 5'd2, a);
        @(negedge clk);
        check("busy_shift", 64'(bus.busy), 64'd1);
        check("in_ready_shift", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        wait_empty();

        // Full-scale and assorted values
        for (int i = 0; i < 4; i++) begin
            send(vals[i], pts[i], a);
            wait_empty();
        end

        // Downstream stall for 10 clocks with a competing request
        bus.out_ready = 1'b0;
        send(24'd777, 5'd4, a);
        hold_bcd = to_bcd(777);
        n = 0;
        while (!bus.out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("stall_seen_ov", 64'(bus.out_valid), 64'd1);
        bus.bin_in   = 24'd5;
        bus.point_in = 5'd1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_ov", 64'(bus.out_valid), 64'd1);
            check("stall_bcd", 64'(bus.bcd_out), 64'(hold_bcd));
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_in_ready", 64'(bus.in_ready), 64'd1);
        check("release_ov", 64'(bus.out_valid), 64'd0);
        check("idle_hold_bcd", 64'(bus.bcd_out), 64'(hold_bcd));
        @(posedge clk);
        #1;
        wait_empty();

        // Back-to-back with in_valid held
        send(24'd125, 5'd0, a1);
        send(24'd625, 5'd1, a2);
        check("b2b_gap", 64'(a2 - a1), 64'd26);
        wait_empty();

        // Reset in the middle of a conversion
        send(24'd4321, 5'd3, a);
        repeat (10) @(posedge clk);
        #1;
        check("busy_mid", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_ov", 64'(bus.out_valid), 64'd0);
        check("abort_bcd", 64'(bus.bcd_out), 64'd0);
        check("abort_point", 64'(bus.point_out), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_in_ready", 64'(bus.in_ready), 64'd1);
        sbq.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(24'd31415, 5'd1, a);
        wait_empty();

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
